// File: rtl/brush_painter.sv
// brush_painter: paints a (2R+1)x(2R+1) dab of pixels around the cursor
// into a frame buffer through a valid/ready pixel write port.
// Optional feature macro: BRUSH_ROUND_EN (round brush instead of square).
module brush_painter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int R      = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button_left,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [2:0]  color,
  input  logic        wr_ready,
  output logic        wr_valid,
  output logic [9:0]  wr_x,
  output logic [8:0]  wr_y,
  output logic [23:0] wr_rgb,
  output logic        busy
);

  typedef enum logic {IDLE, PAINT} state_t;

  localparam logic signed [12:0] RS  = 13'(R);
  localparam logic signed [12:0] WS  = 13'(WIDTH);
  localparam logic signed [12:0] HS  = 13'(HEIGHT);

  state_t             state_q;
  logic [9:0]         latchX_q;
  logic [8:0]         latchY_q;
  logic [2:0]         latchColor_q;
  logic signed [12:0] dx_q, dy_q;
  logic               wrValid_q;
  logic [9:0]         wrX_q;
  logic [8:0]         wrY_q;
  logic [23:0]        wrRgb_q;

  logic signed [12:0] dx_d, dy_d;
  logic signed [12:0] baseX, baseY;
  logic signed [12:0] col_d, row_d;
  logic [2:0]         code;
  logic               hit_d;
  logic [23:0]        rgb_d;
  logic               lastPixel;
  logic               advance;

`ifdef BRUSH_ROUND_EN
  localparam logic signed [25:0] RR = 26'(R * R);
  logic signed [25:0] dxWide, dyWide, dist;
`endif

  function automatic logic [23:0] colorMap(input logic [2:0] c);
    case (c)
      3'b000:  colorMap = 24'hFFFFFF;
      3'b001:  colorMap = 24'hFFFFFF;
      3'b010:  colorMap = 24'h000000;
      3'b011:  colorMap = 24'hFF0000;
      3'b100:  colorMap = 24'h0000FF;
      3'b101:  colorMap = 24'hFFFF00;
      3'b110:  colorMap = 24'h00FF00;
      default: colorMap = 24'h800080;
    endcase
  endfunction

  assign lastPixel = (dx_q == RS) && (dy_q == RS);
  assign advance   = !wrValid_q || wr_ready;

  // Work out the pixel that becomes current at the next edge: the first
  // offset of a new dab when idle, otherwise the raster successor.
  always_comb begin
    dx_d  = dx_q;
    dy_d  = dy_q;
    baseX = {3'b000, latchX_q};
    baseY = {4'b0000, latchY_q};
    code  = latchColor_q;
    if (state_q == IDLE) begin
      dx_d  = -RS;
      dy_d  = -RS;
      baseX = {3'b000, x};
      baseY = {4'b0000, y};
      code  = color;
    end else if (dx_q == RS) begin
      dx_d = -RS;
      dy_d = dy_q + 13'sd1;
    end else begin
      dx_d = dx_q + 13'sd1;
    end
    col_d = baseX + dx_d;
    row_d = baseY + dy_d;
    hit_d = (col_d >= 13'sd0) && (col_d < WS) && (row_d >= 13'sd0) && (row_d < HS);
`ifdef BRUSH_ROUND_EN
    dxWide = 26'(dx_d);
    dyWide = 26'(dy_d);
    dist   = dxWide * dxWide + dyWide * dyWide;
    hit_d  = hit_d && (dist <= RR);
`endif
    rgb_d = colorMap(code);
  end

  // Dab sequencer: latches the press, walks the offsets and registers the write port.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      latchX_q     <= '0;
      latchY_q     <= '0;
      latchColor_q <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      wrValid_q    <= 1'b0;
      wrX_q        <= '0;
      wrY_q        <= '0;
      wrRgb_q      <= '0;
      busy         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (button_left) begin
            state_q      <= PAINT;
            busy         <= 1'b1;
            latchX_q     <= x;
            latchY_q     <= y;
            latchColor_q <= color;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            wrValid_q    <= hit_d;
            wrX_q        <= col_d[9:0];
            wrY_q        <= row_d[8:0];
            wrRgb_q      <= rgb_d;
          end
        end
        PAINT: begin
          if (advance) begin
            if (lastPixel) begin
              state_q   <= IDLE;
              busy      <= 1'b0;
              wrValid_q <= 1'b0;
              wrX_q     <= '0;
              wrY_q     <= '0;
              wrRgb_q   <= '0;
            end else begin
              dx_q      <= dx_d;
              dy_q      <= dy_d;
              wrValid_q <= hit_d;
              wrX_q     <= col_d[9:0];
              wrY_q     <= row_d[8:0];
              wrRgb_q   <= rgb_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_valid = wrValid_q;
  assign wr_x     = wrX_q;
  assign wr_y     = wrY_q;
  assign wr_rgb   = wrRgb_q;

endmodule

// File: tb/tb_brush_painter.sv
// tb_brush_painter: directed self-checking bench for brush_painter (R=2, 640x480).
// Expectations switch to the round brush when BRUSH_ROUND_EN is defined.
module tb_brush_painter;

  logic        clk = 1'b0;
  logic        reset;
  logic        button_left;
  logic [9:0]  x;
  logic [8:0]  y;
  logic [2:0]  color;
  logic        wr_ready;
  logic        wr_valid;
  logic [9:0]  wr_x;
  logic [8:0]  wr_y;
  logic [23:0] wr_rgb;
  logic        busy;

  int passCount  = 0;
  int checkCount = 0;

  int writes, skips, busyCyc, rgbBad;
  int firstX, firstY, lastX, lastY;
  bit gotFirst, sawCorner, sawMidLeft;

`ifdef BRUSH_ROUND_EN
  localparam int A_WRITES = 13, A_FX = 100, A_FY = 98, A_LX = 100, A_LY = 102;
  localparam int B_WRITES = 6,  B_LX = 0, B_LY = 2;
  localparam int A_CORNER = 0;
`else
  localparam int A_WRITES = 25, A_FX = 98, A_FY = 98, A_LX = 102, A_LY = 102;
  localparam int B_WRITES = 9,  B_LX = 2, B_LY = 2;
  localparam int A_CORNER = 1;
`endif

  brush_painter #(.WIDTH(640), .HEIGHT(480), .R(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .button_left(button_left),
    .x          (x),
    .y          (y),
    .color      (color),
    .wr_ready   (wr_ready),
    .wr_valid   (wr_valid),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_rgb     (wr_rgb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp)
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    else
      passCount++;
  endtask

  task automatic applyStimulus(input logic btn, input logic [9:0] px, input logic [8:0] py,
                               input logic [2:0] pc);
    button_left = btn;
    x           = px;
    y           = py;
    color       = pc;
  endtask

  // Press, then change inputs during the dab and collect what the port produces.
  task automatic runDab(input logic [9:0] px, input logic [8:0] py, input logic [2:0] pc,
                        input logic holdBtn, input logic [9:0] laterX,
                        input logic [2:0] laterColor, input logic [23:0] expRgb);
    writes = 0; skips = 0; busyCyc = 0; rgbBad = 0;
    firstX = -1; firstY = -1; lastX = -1; lastY = -1;
    gotFirst = 0; sawCorner = 0; sawMidLeft = 0;
    @(negedge clk) applyStimulus(1'b1, px, py, pc);
    @(negedge clk) applyStimulus(holdBtn, laterX, py, laterColor);
    for (int i = 0; i < 100 && busy; i++) begin
      busyCyc++;
      if (wr_valid) begin
        writes++;
        if (!gotFirst) begin
          firstX = int'(wr_x); firstY = int'(wr_y); gotFirst = 1;
        end
        lastX = int'(wr_x); lastY = int'(wr_y);
        if (wr_rgb !== expRgb) rgbBad++;
        if (wr_x == 10'd98 && wr_y == 9'd98)  sawCorner  = 1;
        if (wr_x == 10'd98 && wr_y == 9'd100) sawMidLeft = 1;
      end else begin
        skips++;
      end
      @(negedge clk);
    end
    checkOutput("dab_ends", busy, 1'b0);
  endtask

  initial begin
    int seen;
    wr_ready = 1'b1;
    reset    = 1'b0;
    applyStimulus(1'b0, 10'd0, 9'd0, 3'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", wr_valid, 1'b0);
    checkOutput("rst_busy",  busy,     1'b0);
    checkOutput("rst_x",     wr_x,     10'd0);
    checkOutput("rst_y",     wr_y,     9'd0);
    checkOutput("rst_rgb",   wr_rgb,   24'd0);
    reset = 1'b1;
    @(negedge clk);

    // Centre dab, red
    runDab(10'd100, 9'd100, 3'b011, 1'b0, 10'd100, 3'b011, 24'hFF0000);
    checkOutput("A_writes", writes,  A_WRITES);
    checkOutput("A_busy",   busyCyc, 25);
    checkOutput("A_first",  {firstX[15:0], firstY[15:0]}, {16'(A_FX), 16'(A_FY)});
    checkOutput("A_last",   {lastX[15:0], lastY[15:0]},   {16'(A_LX), 16'(A_LY)});
    checkOutput("A_rgb",    rgbBad, 0);
    checkOutput("A_corner", sawCorner,  A_CORNER);
    checkOutput("A_midleft", sawMidLeft, 1);

    // Corner dab, black, button held through the dab
    runDab(10'd0, 9'd0, 3'b010, 1'b1, 10'd0, 3'b010, 24'h000000);
    checkOutput("B_writes", writes,  B_WRITES);
    checkOutput("B_skips",  skips,   25 - B_WRITES);
    checkOutput("B_busy",   busyCyc, 25);
    checkOutput("B_first",  {firstX[15:0], firstY[15:0]}, 32'h0);
    checkOutput("B_last",   {lastX[15:0], lastY[15:0]},   {16'(B_LX), 16'(B_LY)});
    checkOutput("B_rgb",    rgbBad, 0);
    @(negedge clk) applyStimulus(1'b0, 10'd0, 9'd0, 3'b010);
    checkOutput("B_restart", busy, 1'b1);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checkOutput("B_drain", busy, 1'b0);

    // Back-pressure on the first pixel (square brush coordinates)
`ifndef BRUSH_ROUND_EN
    wr_ready = 1'b0;
    @(negedge clk) applyStimulus(1'b1, 10'd100, 9'd100, 3'b110);
    @(negedge clk) applyStimulus(1'b0, 10'd100, 9'd100, 3'b110);
    for (int i = 0; i < 3; i++) begin
      checkOutput("C_hold_valid", wr_valid, 1'b1);
      checkOutput("C_hold_xy", {wr_x, wr_y}, {10'd98, 9'd98});
      checkOutput("C_hold_rgb", wr_rgb, 24'h00FF00);
      if (i < 2) @(negedge clk);
    end
    wr_ready = 1'b1;
    @(negedge clk);
    checkOutput("C_second_xy", {wr_x, wr_y}, {10'd99, 9'd98});
    checkOutput("C_second_valid", wr_valid, 1'b1);
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    checkOutput("C_drain", busy, 1'b0);
`endif

    // Inputs move during the dab; erase colour
    runDab(10'd100, 9'd100, 3'b000, 1'b0, 10'd300, 3'b011, 24'hFFFFFF);
    checkOutput("D_writes", writes, A_WRITES);
    checkOutput("D_first",  {firstX[15:0], firstY[15:0]}, {16'(A_FX), 16'(A_FY)});
    checkOutput("D_last",   {lastX[15:0], lastY[15:0]},   {16'(A_LX), 16'(A_LY)});
    checkOutput("D_rgb",    rgbBad, 0);

    // Reset while pixel 10 is current
    @(negedge clk) applyStimulus(1'b1, 10'd100, 9'd100, 3'b101);
    @(negedge clk) applyStimulus(1'b0, 10'd100, 9'd100, 3'b101);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("E_valid", wr_valid, 1'b0);
    checkOutput("E_busy",  busy,     1'b0);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wr_valid || busy) seen++;
    end
    checkOutput("E_quiet", seen, 0);

    // Reset and press on the same edge
    reset = 1'b0;
    applyStimulus(1'b1, 10'd100, 9'd100, 3'b011);
    @(negedge clk);
    checkOutput("F_busy",  busy,     1'b0);
    checkOutput("F_valid", wr_valid, 1'b0);
    reset = 1'b1;
    applyStimulus(1'b0, 10'd100, 9'd100, 3'b011);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
